// File: rtl/mm_job_arbiter.sv
// Round-robin arbiter that shares one Montgomery multiplier and the host port of
// its bridge BRAM among NREQ requesters, with an optional BUSY/DRAIN watchdog.
module mm_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int s       = 8,
    parameter int TIMEOUT = 0,
    localparam int AW     = $clog2(4 * s)
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      go_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      job_done_o,
    output logic                 err_o,
    input  logic [NREQ-1:0]      cli_we_i,
    input  logic [NREQ-1:0]      cli_en_i,
    input  logic [NREQ*AW-1:0]   cli_addr_i,
    input  logic [NREQ*17-1:0]   cli_din_i,
    output logic [16:0]          cli_dout_o,
    output logic                 bram_en_o,
    output logic                 bram_we_o,
    output logic [31:0]          bram_addr_o,
    output logic [16:0]          bram_din_o,
    input  logic [16:0]          bram_dout_i,
    output logic                 mm_start_o,
    input  logic                 mm_done_i
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_START, S_BUSY, S_RESULT, S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d, last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d, jd_q, jd_d;
    logic            err_q, err_d, start_q, start_d;
    logic            en_q, en_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [16:0]     din_q, din_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic [OW-1:0]   pick_s;
    logic            wd_hit_s;

    // First set request searching upward from last+1 with wrap; scanning downward
    // lets the nearest candidate overwrite farther ones.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] pick;
        logic [OW:0]   idx;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx  = {1'b0, last} + (OW+1)'(i);
            idx  = (idx >= (OW+1)'(NREQ)) ? idx - (OW+1)'(NREQ) : idx;
            pick = req[idx[OW-1:0]] ? idx[OW-1:0] : pick;
        end
        return pick;
    endfunction

    assign pick_s   = rr_pick(req_i, last_q);
    assign wd_hit_s = (TIMEOUT > 0) && (wd_q == CW'(TIMEOUT - 1));

    // Next-state, grant, handshake and BRAM-mux logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        jd_d    = '0;
        err_d   = err_q;
        start_d = 1'b0;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        wd_d    = wd_q;

        if (state_q == S_GRANT || state_q == S_RESULT) begin
            en_d   = cli_en_i[owner_q];
            we_d   = cli_we_i[owner_q];
            addr_d = cli_addr_i[owner_q*AW +: AW];
            din_d  = cli_din_i[owner_q*17 +: 17];
        end else begin
            en_d = 1'b0;
            we_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    owner_d = pick_s;
                    last_d  = pick_s;
                    gnt_d   = NREQ'(1'b1) << pick_s;
                    state_d = S_GRANT;
                end else begin
                    gnt_d = '0;
                end
            end
            S_GRANT, S_RESULT: begin
                // A request drop beats a simultaneous go.
                if (!req_i[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (go_i[owner_q]) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = req_i[owner_q] ? S_BUSY : S_DRAIN;
            end
            S_BUSY: begin
                if (mm_done_i && req_i[owner_q]) begin
                    state_d        = S_RESULT;
                    jd_d[owner_q]  = 1'b1;
                end else if (mm_done_i) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (wd_hit_s) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    wd_d    = wd_q + CW'(1'b1);
                    state_d = req_i[owner_q] ? S_BUSY : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mm_done_i) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (wd_hit_s) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    wd_d = wd_q + CW'(1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; last owner resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            gnt_q   <= '0;
            jd_q    <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            jd_q    <= jd_d;
            err_q   <= err_d;
            start_q <= start_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign job_done_o  = jd_q;
    assign err_o       = err_q;
    assign mm_start_o  = start_q;
    assign bram_en_o   = en_q;
    assign bram_we_o   = we_q;
    assign bram_addr_o = {{(32-AW){1'b0}}, addr_q};
    assign bram_din_o  = din_q;
    assign cli_dout_o  = bram_dout_i;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed, table-driven bench for mm_job_arbiter with a one-cycle-latency BRAM model.
module tb_mm_job_arbiter;

    localparam int NREQ = 4;
    localparam int S    = 8;
    localparam int TO   = 50;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NREQ-1:0]      req_i = '0, go_i = '0, cli_we_i = '0, cli_en_i = '0;
    logic [NREQ*AW-1:0]   cli_addr_i = '0;
    logic [NREQ*17-1:0]   cli_din_i = '0;
    logic                 mm_done_i = 1'b0;
    logic [NREQ-1:0]      gnt_o, job_done_o;
    logic                 err_o, bram_en_o, bram_we_o, mm_start_o;
    logic [31:0]          bram_addr_o;
    logic [16:0]          bram_din_o, cli_dout_o, bram_dout;
    logic [16:0]          mem [0:31];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mm_job_arbiter #(.NREQ(NREQ), .s(S), .TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_n_i(reset_n), .req_i(req_i), .go_i(go_i),
        .gnt_o(gnt_o), .job_done_o(job_done_o), .err_o(err_o),
        .cli_we_i(cli_we_i), .cli_en_i(cli_en_i), .cli_addr_i(cli_addr_i),
        .cli_din_i(cli_din_i), .cli_dout_o(cli_dout_o),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
        .bram_din_o(bram_din_o), .bram_dout_i(bram_dout),
        .mm_start_o(mm_start_o), .mm_done_i(mm_done_i)
    );

    // Bridge BRAM host port: registered read, write-first not needed.
    always @(posedge clk) begin
        if (bram_en_o) begin
            if (bram_we_o) mem[bram_addr_o[4:0]] <= bram_din_o;
            bram_dout <= mem[bram_addr_o[4:0]];
        end
    end

    typedef struct {
        logic [3:0]    req, go, en, we;
        logic [AW-1:0] addr;
        logic [16:0]   din;
        logic          done;
        int            rep;
        logic [3:0]    e_gnt, e_jd;
        logic          e_start, e_en, e_we, e_err, chk_rd;
        logic [16:0]   e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] req, go, en, we, input logic [AW-1:0] addr,
                       input logic [16:0] din, input logic done, input int rep,
                       input logic [3:0] e_gnt, e_jd, input logic e_start, e_en, e_we,
                       e_err, chk_rd, input logic [16:0] e_rd);
        vec_t v;
        v.req = req; v.go = go; v.en = en; v.we = we; v.addr = addr; v.din = din;
        v.done = done; v.rep = rep; v.e_gnt = e_gnt; v.e_jd = e_jd;
        v.e_start = e_start; v.e_en = e_en; v.e_we = e_we; v.e_err = e_err;
        v.chk_rd = chk_rd; v.e_rd = e_rd;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_i = '0; go_i = '0; cli_we_i = '0; cli_en_i = '0; mm_done_i = 1'b0;
        #2;
        chk("rst_gnt", gnt_o, 32'h0);
        chk("rst_jd", job_done_o, 32'h0);
        chk("rst_err", err_o, 32'h0);
        chk("rst_start", mm_start_o, 32'h0);
        chk("rst_en", bram_en_o, 32'h0);
        chk("rst_we", bram_we_o, 32'h0);
        chk("rst_addr", bram_addr_o, 32'h0);
        chk("rst_din", bram_din_o, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One job for owner k with all requesters held, then release and expect nxt.
    task automatic do_job(input int k, input int nxt);
        go_i = 4'b0001 << k;
        step();
        chk("rot_start", mm_start_o, 32'h1);
        go_i = '0;
        step();
        chk("rot_start_end", mm_start_o, 32'h0);
        step();
        mm_done_i = 1'b1;
        step();
        chk("rot_jd", job_done_o, 32'(4'b0001 << k));
        mm_done_i = 1'b0;
        req_i[k] = 1'b0;
        step();
        chk("rot_dead", gnt_o, 32'h0);
        req_i[k] = 1'b1;
        step();
        chk("rot_next", gnt_o, 32'(4'b0001 << nxt));
    endtask

    initial begin
        do_reset();

        // req,go,en,we,addr,din,done,rep | gnt,jd,start,en,we,err,chk_rd,rd
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0011, 4'b0011, 5'd0, 17'h1AAAA, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 5'd1, 17'h00011, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 5'd2, 17'h12345, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 5'd3, 17'h0FFFF, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0010, 4'b0010, 5'd7, 17'h1FFFF, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0001, 4'b0001, 4'b0001, 5'd0, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 5'd0, 17'h00000, 1'b0, 19, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b1, 1,  4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 5'd2, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h1AAAA);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h12345);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'd0, 17'h00000, 1'b0, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                req_i      = tbl[i].req;
                go_i       = tbl[i].go;
                cli_en_i   = tbl[i].en;
                cli_we_i   = tbl[i].we;
                cli_addr_i = {NREQ{tbl[i].addr}};
                cli_din_i  = {NREQ{tbl[i].din}};
                mm_done_i  = tbl[i].done;
                step();
                chk($sformatf("v%0d_gnt", i), gnt_o, 32'(tbl[i].e_gnt));
                chk($sformatf("v%0d_jd", i), job_done_o, 32'(tbl[i].e_jd));
                chk($sformatf("v%0d_start", i), mm_start_o, 32'(tbl[i].e_start));
                chk($sformatf("v%0d_en", i), bram_en_o, 32'(tbl[i].e_en));
                chk($sformatf("v%0d_we", i), bram_we_o, 32'(tbl[i].e_we));
                chk($sformatf("v%0d_err", i), err_o, 32'(tbl[i].e_err));
                if (tbl[i].e_en) begin
                    chk($sformatf("v%0d_addr", i), bram_addr_o, 32'(tbl[i].addr));
                    chk($sformatf("v%0d_din", i), bram_din_o, 32'(tbl[i].din));
                end
                if (tbl[i].chk_rd) begin
                    chk($sformatf("v%0d_rd", i), cli_dout_o, 32'(tbl[i].e_rd));
                end
            end
        end
        cli_en_i = '0; cli_we_i = '0; mm_done_i = 1'b0; go_i = '0;

        // Round robin 0,1,2,3,0 with every requester held.
        do_reset();
        req_i = 4'b1111;
        step();
        chk("rot_first", gnt_o, 32'h1);
        for (int k = 0; k < NREQ; k++) begin
            do_job(k, (k + 1) % NREQ);
        end

        // Owner 2 drops during BUSY: drain, no job_done, then owner 3.
        do_reset();
        req_i = 4'b1100;
        step();
        chk("drn_gnt", gnt_o, 32'h4);
        go_i = 4'b0100;
        step();
        chk("drn_start", mm_start_o, 32'h1);
        go_i = '0;
        step();
        req_i = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("drn_hold_gnt", gnt_o, 32'h4);
            chk("drn_no_jd", job_done_o, 32'h0);
        end
        mm_done_i = 1'b1;
        step();
        chk("drn_rel_gnt", gnt_o, 32'h0);
        chk("drn_rel_jd", job_done_o, 32'h0);
        mm_done_i = 1'b0;
        step();
        chk("drn_next", gnt_o, 32'h8);

        // Watchdog: owner 3 starts, no done ever arrives.
        req_i = 4'b1001;
        go_i  = 4'b1000;
        step();
        chk("wd_start", mm_start_o, 32'h1);
        go_i = '0;
        step();
        repeat (TO - 1) step();
        chk("wd_err_early", err_o, 32'h0);
        chk("wd_gnt_early", gnt_o, 32'h8);
        step();
        chk("wd_err", err_o, 32'h1);
        chk("wd_gnt_clr", gnt_o, 32'h0);
        chk("wd_no_jd", job_done_o, 32'h0);
        step();
        chk("wd_next", gnt_o, 32'h1);
        req_i = '0;
        step();
        step();
        chk("wd_sticky", err_o, 32'h1);

        // Reset in the middle of BUSY, then requester 0 wins first.
        do_reset();
        req_i = 4'b0010;
        step();
        chk("mr_gnt", gnt_o, 32'h2);
        go_i = 4'b0010;
        step();
        go_i = '0;
        step();
        step();
        do_reset();
        req_i = 4'b1111;
        step();
        chk("mr_first", gnt_o, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
